hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage CPU. It drives the `pause` and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding muxes.
- It detects load-use hazards, branch/jump redirects and a retiring `halt`, and runs the halt/resume state machine.
- It keeps cycle, stall and flush statistics counters for the board display.

Parameters:
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- id_jump  in  1  j/jal/jr resolved in ID
- ex_rs  in  5  rs of the instruction in EX
- ex_rt  in  5  rt of the instruction in EX
- ex_MemToReg  in  1  ID/EX MemToReg
- ex_RegWrite  in  1  ID/EX RegWrite
- ex_RW  in  5  ID/EX destination register
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_RegWrite  in  1  EX/MEM RegWrite_out
- mem_MemToReg  in  1  EX/MEM MemToReg_out
- mem_jal  in  1  EX/MEM jal_out
- mem_RW  in  5  EX/MEM RW_out
- wb_RegWrite  in  1  MEM/WB RegWrite
- wb_RW  in  5  MEM/WB destination register
- wb_halt  in  1  MEM/WB halt (halt retiring)
- go  in  1  debounced resume button, level
- pause_pc  out  1  hold PC
- pause_if_id  out  1  hold IF/ID
- flush_if_id  out  1  bubble IF/ID
- flush_id_ex  out  1  bubble ID/EX
- pause_all  out  1  hold every pipeline register, including EX/MEM and MEM/WB `pause`
- fwd_a  out  2  EX operand A select
- fwd_b  out  2  EX operand B select
- halted  out  1  state==HALTED
- cycle_cnt  out  CNT_W  executed cycles
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- **State machine.** States are RUN, HALTED and RESUME. Reset puts the block in RUN, clears all counters and sets go_q=0.
  - RUN & wb_halt: go to HALTED.
  - HALTED & (go & ~go_q), a rising edge of go: go to RESUME.
  - RESUME: go to RUN after exactly 1 cycle. wb_halt is ignored in RESUME so the frozen halt can leave MEM/WB.
- **pause_all.** pause_all = (state==HALTED) | (state==RUN & wb_halt), combinational, so the pipeline freezes in the same cycle the halt retires.
  - When pause_all=1, pause_pc=pause_if_id=1 and both flushes are 0.
- **Load-use hazard.** load_use = ex_MemToReg & ex_RegWrite & ex_RW!=0 & ((id_rs_used & id_rs==ex_RW) | (id_rt_used & id_rt==ex_RW)).
  - Effect: pause_pc=1, pause_if_id=1, flush_id_ex=1.
- **Priority, highest first:** pause_all > ex_branch_taken > load_use > id_jump.
  - ex_branch_taken: flush_if_id=1 and flush_id_ex=1. A load_use or id_jump in the same cycle is discarded.
  - load_use together with id_jump: stall only, no flush. The jump re-evaluates on the next cycle.
  - id_jump alone: flush_if_id=1.
- **Forwarding, per operand** (fwd_a uses ex_rs, fwd_b uses ex_rt). Register 0 is never forwarded.
  - 2'b11: mem_RegWrite & mem_jal & mem_RW==src. Selects the EX/MEM link value (p).
  - 2'b01: mem_RegWrite & ~mem_MemToReg & ~mem_jal & mem_RW==src. Selects the EX/MEM ALU result R.
  - 2'b10: otherwise, wb_RegWrite & wb_RW==src. Selects the MEM/WB write-back data.
  - 2'b00: register file.
  - EX/MEM beats MEM/WB.
  - A load sitting in EX/MEM never forwards; load_use has already stalled it.
- **Counters.** Each counter wraps modulo 2^CNT_W and updates on the clock edge from the current-cycle conditions.
  - cycle_cnt: +1 whenever pause_all=0.
  - stall_cnt: +1 when load_use wins priority.
  - flush_cnt: +1 when ex_branch_taken wins, or when id_jump wins. One increment per cycle at most.
  - All counters are frozen while pause_all=1.
- **Reset mid-halt.** rst in any state returns to RUN with zero counters; rst wins over go.
- **Output reset values.** Only state, go_q and the counters are sequential. After reset the control outputs are all 0 when all inputs are 0.

Decomposition:
- Shared package `cpu_ctrl_pkg` holds:
  - FWD_RF=2'b00, FWD_MEM_R=2'b01, FWD_WB=2'b10, FWD_MEM_P=2'b11;
  - state encoding RUN=2'd0, HALTED=2'd1, RESUME=2'd2.
- One natural sub-module, `fwd_unit`: purely combinational, instantiated once per operand (src, mem_*, wb_* → 2-bit select).

Test Plan:
- **Load-use:** lw $8 in EX (ex_MemToReg=1, ex_RegWrite=1, ex_RW=8); ID add reads rs=8 → pause_pc=pause_if_id=flush_id_ex=1 for 1 cycle; stall_cnt 0→1.
- **Branch wins:** ex_branch_taken=1 together with id_jump=1 and a load_use condition → flush_if_id=flush_id_ex=1, pause_pc=0; flush_cnt +1; stall_cnt unchanged.
- **Forwarding priority:** ex_rs=5, mem_RW=5 (ALU), wb_RW=5 → fwd_a=01. Set mem_jal=1, mem_RW=31, ex_rt=31 → fwd_b=11. Set ex_rs=0 with all RW=0 → fwd_a=00.
- **Halt/resume:** wb_halt=1 in RUN → pause_all=1 that cycle; halted=1 next cycle; cycle_cnt frozen over 10 cycles. go 0→1 → RESUME for 1 cycle with pause_all=0 despite wb_halt=1, then RUN. go held high → no second resume.
- **Reset mid-halt:** in HALTED with cycle_cnt=37, assert rst → next cycle state RUN, halted=0, all counters 0.
- **Wrap:** CNT_W=4; run 17 unpaused cycles → cycle_cnt=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the CPU pipeline control logic
package cpu_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEM_R = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;
  localparam logic [1:0] FWD_MEM_P = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    RESUME = 2'd2
  } state_t;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand forwarding select for one source register
module fwd_unit
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_mem_reg_write,
  input  logic       i_mem_mem_to_reg,
  input  logic       i_mem_jal,
  input  logic [4:0] i_mem_rw,
  input  logic       i_wb_reg_write,
  input  logic [4:0] i_wb_rw,
  output logic [1:0] o_sel
);

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nz  = (i_src != 5'd0);
  assign w_mem_hit = w_src_nz & i_mem_reg_write & (i_mem_rw == i_src);
  assign w_wb_hit  = w_src_nz & i_wb_reg_write & (i_wb_rw == i_src);

  // A load in EX/MEM has no data yet; it falls through to the MEM/WB check.
  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit & i_mem_jal)
      o_sel = FWD_MEM_P;
    else if (w_mem_hit & ~i_mem_mem_to_reg)
      o_sel = FWD_MEM_R;
    else if (w_wb_hit)
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control, halt FSM and stats counters
module hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_MemToReg,
  input  logic             ex_RegWrite,
  input  logic [4:0]       ex_RW,
  input  logic             ex_branch_taken,
  input  logic             mem_RegWrite,
  input  logic             mem_MemToReg,
  input  logic             mem_jal,
  input  logic [4:0]       mem_RW,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_RW,
  input  logic             wb_halt,
  input  logic             go,
  output logic             pause_pc,
  output logic             pause_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pause_all,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           r_state;
  logic             r_go_q;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_pause_all;
  logic w_load_use;
  logic w_stall_win;
  logic w_flush_win;

  // Freeze in the same cycle the halt retires; RESUME lets that halt drain out.
  assign w_pause_all = (r_state == HALTED) | ((r_state == RUN) & wb_halt);

  assign w_load_use = ex_MemToReg & ex_RegWrite & (ex_RW != 5'd0) &
                      ((id_rs_used & (id_rs == ex_RW)) |
                       (id_rt_used & (id_rt == ex_RW)));

  assign w_stall_win = ~w_pause_all & ~ex_branch_taken & w_load_use;
  assign w_flush_win = ~w_pause_all &
                       (ex_branch_taken | (~w_load_use & id_jump));

  always_comb begin
    pause_pc    = 1'b0;
    pause_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (w_pause_all) begin
      pause_pc    = 1'b1;
      pause_if_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_load_use) begin
      pause_pc    = 1'b1;
      pause_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (id_jump) begin
      flush_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_go_q  <= 1'b0;
    end else begin
      r_go_q <= go;
      case (r_state)
        RUN:     if (wb_halt) r_state <= HALTED;
        HALTED:  if (go & ~r_go_q) r_state <= RESUME;
        RESUME:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_pause_all) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_stall_win) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_win) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  fwd_unit u_fwd_a (
    .i_src            (ex_rs),
    .i_mem_reg_write  (mem_RegWrite),
    .i_mem_mem_to_reg (mem_MemToReg),
    .i_mem_jal        (mem_jal),
    .i_mem_rw         (mem_RW),
    .i_wb_reg_write   (wb_RegWrite),
    .i_wb_rw          (wb_RW),
    .o_sel            (fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src            (ex_rt),
    .i_mem_reg_write  (mem_RegWrite),
    .i_mem_mem_to_reg (mem_MemToReg),
    .i_mem_jal        (mem_jal),
    .i_mem_rw         (mem_RW),
    .i_wb_reg_write   (wb_RegWrite),
    .i_wb_rw          (wb_RW),
    .o_sel            (fwd_b)
  );

  assign pause_all = w_pause_all;
  assign halted    = (r_state == HALTED);
  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
